// File: rtl/add_sub_pkg.sv
// Shared constants for the registered adder/subtractor: mode encoding,
// default operand width and saturation limits at that width.
package add_sub_pkg;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic [DEFAULT_WIDTH-1:0] SAT_MAX_DEF = {1'b0, {(DEFAULT_WIDTH-1){1'b1}}};
  localparam logic [DEFAULT_WIDTH-1:0] SAT_MIN_DEF = {1'b1, {(DEFAULT_WIDTH-1){1'b0}}};
endpackage

// File: rtl/add_sub_core.sv
// Combinational ripple-carry add/subtract: a + (b ^ {mode}) + mode, with
// carry out of the MSB and signed-overflow detection.
module add_sub_core
  import add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             ovfl_o
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             cy;

  assign b_eff = b_i ^ {WIDTH{mode_i == MODE_SUB}};

  // Carry-in of bit 0 is the mode bit, completing the two's-complement negate.
  always_comb begin
    sum = '0;
    cy  = mode_i;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a_i[i] ^ b_eff[i] ^ cy;
      cy     = (a_i[i] & b_eff[i]) | (a_i[i] & cy) | (b_eff[i] & cy);
    end
  end

  assign sum_o   = sum;
  assign carry_o = cy;
  assign ovfl_o  = (a_i[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);

endmodule

// File: rtl/add_sub_unit.sv
// Registered two's-complement adder/subtractor, 1-cycle latency.
// Define ADD_SUB_SATURATE_EN to clamp the result on signed overflow.
module add_sub_unit
  import add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic [WIDTH-1:0] result,
  output logic             ovfl,
  output logic             carry_out,
  output logic             out_valid
);

  logic [WIDTH-1:0] sum;
  logic             sum_c;
  logic             sum_ov;
  logic [WIDTH-1:0] result_d, result_q;
  logic             ovfl_q, carry_q, valid_q;

  add_sub_core #(.WIDTH(WIDTH)) u_core (
    .a_i     (a),
    .b_i     (b),
    .mode_i  (mode),
    .sum_o   (sum),
    .carry_o (sum_c),
    .ovfl_o  (sum_ov)
  );

`ifdef ADD_SUB_SATURATE_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  // On overflow the true result has the sign of a.
  always_comb begin
    result_d = sum;
    if (sum_ov) result_d = a[WIDTH-1] ? SAT_MIN : SAT_MAX;
  end
`else
  always_comb begin
    result_d = sum;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      ovfl_q   <= 1'b0;
      carry_q  <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        result_q <= result_d;
        ovfl_q   <= sum_ov;
        carry_q  <= sum_c;
      end
    end
  end

  assign result    = result_q;
  assign ovfl      = ovfl_q;
  assign carry_out = carry_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_add_sub_unit.sv
// Self-checking bench for add_sub_unit at WIDTH=8: directed vectors, random
// streams against an integer-arithmetic model, valid gaps and async reset.
module tb_add_sub_unit;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         mode = 1'b0;
  logic [W-1:0] result;
  logic         ovfl, carry_out, out_valid;

  int checks = 0;
  int failures = 0;

  // Expected held output state
  logic [W-1:0] e_res = '0;
  logic         e_ov = 1'b0, e_c = 1'b0;

  add_sub_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .mode(mode),
    .result(result), .ovfl(ovfl), .carry_out(carry_out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Reference: true signed/unsigned arithmetic, overflow = true value out of range.
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic m,
                                output logic [W-1:0] r, output logic o, output logic c);
    int sx, sy, t, ux, uy;
    sx = $signed(x); sy = $signed(y);
    ux = int'(x);    uy = int'(y);
    t  = m ? sx - sy : sx + sy;
    o  = (t > 127) || (t < -128);
    c  = m ? (ux >= uy) : (ux + uy > 255);
    r  = W'(t & 255);
`ifdef ADD_SUB_SATURATE_EN
    if (o) r = (t > 0) ? 8'h7F : 8'h80;
`endif
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
    @(negedge clk);
    in_valid = v; a = x; b = y; mode = m;
    if (v) model(x, y, m, e_res, e_ov, e_c);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, result, ovfl, carry_out} !== 11'd0) begin
      failures++;
      $display("FAIL reset: got v=%b r=%h o=%b c=%b want all 0", out_valid, result, ovfl, carry_out);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [W-1:0] va[6] = '{8'h00, 8'h00, 8'h01, 8'h6D, 8'h80, 8'h85};
    logic [W-1:0] vb[6] = '{8'h01, 8'h01, 8'h81, 8'h45, 8'h9C, 8'h21};
    logic         vm[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] xr[6] = '{8'h01, 8'hFF, 8'h80, 8'hB2, 8'h1C, 8'h64};
    logic         xo[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic         xc[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
`ifdef ADD_SUB_SATURATE_EN
    xr[2] = 8'h7F; xr[3] = 8'h7F; xr[4] = 8'h80; xr[5] = 8'h80;
`endif
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, va[i], vb[i], vm[i]);
      checks++;
      if ({out_valid, result, ovfl, carry_out} !== {1'b1, xr[i], xo[i], xc[i]}) begin
        failures++;
        $display("FAIL directed[%0d] %h %s %h: got v=%b r=%h o=%b c=%b want v=1 r=%h o=%b c=%b",
                 i, va[i], vm[i] ? "-" : "+", vb[i], out_valid, result, ovfl, carry_out,
                 xr[i], xo[i], xc[i]);
      end
    end
  endtask

  task automatic test_back_to_back(input int n, input bit gaps);
    logic v;
    for (int i = 0; i < n; i++) begin
      v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      drive(v, W'($urandom), W'($urandom), 1'($urandom));
      checks++;
      if ({out_valid, result, ovfl, carry_out} !== {v, e_res, e_ov, e_c}) begin
        failures++;
        $display("FAIL random[%0d] %h %s %h iv=%b: got v=%b r=%h o=%b c=%b want v=%b r=%h o=%b c=%b",
                 i, a, mode ? "-" : "+", b, v, out_valid, result, ovfl, carry_out,
                 v, e_res, e_ov, e_c);
      end
    end
  endtask

  task automatic test_valid_gap();
    drive(1'b1, 8'h12, 8'h34, 1'b0);
    drive(1'b0, 8'hAA, 8'h55, 1'b1);
    checks++;
    if ({out_valid, result, ovfl, carry_out} !== {1'b0, 8'h46, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL gap_hold: got v=%b r=%h o=%b c=%b want v=0 r=46 o=0 c=0",
               out_valid, result, ovfl, carry_out);
    end
    drive(1'b1, 8'h10, 8'h20, 1'b1);
    checks++;
    if ({out_valid, result, ovfl, carry_out} !== {1'b1, 8'hF0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL gap_resume: got v=%b r=%h o=%b c=%b want v=1 r=f0 o=0 c=0",
               out_valid, result, ovfl, carry_out);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 8'h7F, 8'h01, 1'b0);
    @(negedge clk);
    a = 8'h33; b = 8'h44;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, result, ovfl, carry_out} !== 11'd0) begin
      failures++;
      $display("FAIL async_reset: got v=%b r=%h o=%b c=%b want all 0", out_valid, result, ovfl, carry_out);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, result} !== 9'd0) begin
      failures++;
      $display("FAIL reset_hold: got v=%b r=%h want 0", out_valid, result);
    end
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, result} !== 9'd0) begin
      failures++;
      $display("FAIL post_reset_idle: got v=%b r=%h want 0", out_valid, result);
    end
    drive(1'b1, 8'h33, 8'h44, 1'b0);
    checks++;
    if ({out_valid, result, ovfl, carry_out} !== {1'b1, 8'h77, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL first_after_reset: got v=%b r=%h o=%b c=%b want v=1 r=77 o=0 c=0",
               out_valid, result, ovfl, carry_out);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back(200, 1'b0);
    test_back_to_back(200, 1'b1);
    test_valid_gap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
